// File: rtl/path_writeback_fsm.sv
// Writes a pathfinder result path into the shared bridge memory: node words from base+2,
// 0xFFFF terminator, count word at base. Define PATH_CHECKSUM_EN to append an XOR checksum word.
module path_writeback_fsm #(
  parameter logic [15:0] PATH_BASE_ADDR = 16'h0900,
  parameter int          MAX_LEN        = 64,
  parameter int          FIFO_DEPTH     = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        node_valid,
  output logic        node_ready,
  input  logic [15:0] node_id,
  input  logic        node_last,
  input  logic        bus_grant,
  output logic [15:0] address,
  output logic [15:0] writedata,
  output logic        write_enable,
  output logic        io_enable,
  output logic [15:0] path_len,
  output logic        overflow,
  output logic        finished
);

  localparam int IDXW = $clog2(MAX_LEN + 1);
  localparam int PTRW = $clog2(FIFO_DEPTH);
  localparam logic [IDXW-1:0] MAX_IDX   = IDXW'(MAX_LEN);
  localparam logic [IDXW-1:0] IDX_ONE   = IDXW'(1);
  localparam logic [PTRW:0]   FIFO_FULL = (PTRW+1)'(FIFO_DEPTH);
  localparam logic [PTRW-1:0] PTR_ONE   = PTRW'(1);
  localparam logic [PTRW:0]   CNT_ONE   = (PTRW+1)'(1);

`ifdef PATH_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_WRITING, S_TERM, S_COUNT, S_CHECKSUM, S_FINISH} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_WRITING, S_TERM, S_COUNT, S_FINISH} state_t;
`endif

  state_t          state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            ovf_q, ovf_d;
  logic [15:0]     addr_q, addr_d;
  logic [15:0]     wdata_q, wdata_d;
  logic            we_q, we_d;
  logic            io_q, io_d;
  logic [15:0]     plen_q, plen_d;
  logic [PTRW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [PTRW:0]   cnt_q, cnt_d;
  logic [16:0]     mem_q [FIFO_DEPTH];
`ifdef PATH_CHECKSUM_EN
  logic [15:0]     csum_q, csum_d;
`endif

  logic        fifo_empty, fifo_full, push, pop, flush;
  logic [15:0] head_id, idx_off;
  logic        head_last;

  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == FIFO_FULL);
  assign pop        = (state_q == S_WRITING) && !fifo_empty && bus_grant;
  // A full FIFO still accepts when it frees a slot in the same cycle.
  assign node_ready = (state_q == S_WRITING) && (!fifo_full || pop);
  assign push       = node_valid && node_ready;
  assign head_id    = mem_q[rd_q][15:0];
  assign head_last  = mem_q[rd_q][16];
  assign idx_off    = 16'(idx_q) << 1;

  assign address      = addr_q;
  assign writedata    = wdata_q;
  assign write_enable = we_q;
  assign io_enable    = io_q;
  assign path_len     = plen_q;
  assign overflow     = ovf_q;
  assign finished     = (state_q == S_FINISH);

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= {node_last, node_id};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      ovf_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      io_q    <= 1'b1;
      plen_q  <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
`ifdef PATH_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ovf_q   <= ovf_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      io_q    <= io_d;
      plen_q  <= plen_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
`ifdef PATH_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ovf_d   = ovf_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    plen_d  = plen_q;
    flush   = 1'b0;
`ifdef PATH_CHECKSUM_EN
    csum_d  = csum_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_WRITING;
          idx_d   = '0;
          ovf_d   = 1'b0;
          flush   = 1'b1;
`ifdef PATH_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      S_WRITING: begin
        if (pop) begin
          // 0xFFFF is an in-band end marker and never reaches memory.
          if (head_id != 16'hFFFF) begin
            if (idx_q < MAX_IDX) begin
              addr_d  = PATH_BASE_ADDR + 16'd2 + idx_off;
              wdata_d = head_id;
              we_d    = 1'b1;
              idx_d   = idx_q + IDX_ONE;
`ifdef PATH_CHECKSUM_EN
              csum_d  = csum_q ^ head_id;
`endif
            end else begin
              ovf_d = 1'b1;
            end
          end
          if (head_last || head_id == 16'hFFFF) state_d = S_TERM;
        end
      end
      S_TERM: begin
        if (bus_grant) begin
          addr_d  = PATH_BASE_ADDR + 16'd2 + idx_off;
          wdata_d = 16'hFFFF;
          we_d    = 1'b1;
          state_d = S_COUNT;
        end
      end
      S_COUNT: begin
        if (bus_grant) begin
          addr_d  = PATH_BASE_ADDR;
          wdata_d = 16'(idx_q);
          we_d    = 1'b1;
          plen_d  = 16'(idx_q);
`ifdef PATH_CHECKSUM_EN
          state_d = S_CHECKSUM;
`else
          state_d = S_FINISH;
`endif
        end
      end
`ifdef PATH_CHECKSUM_EN
      S_CHECKSUM: begin
        if (bus_grant) begin
          addr_d  = PATH_BASE_ADDR + 16'd4 + idx_off;
          wdata_d = csum_q;
          we_d    = 1'b1;
          state_d = S_FINISH;
        end
      end
`endif
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    io_d = !we_d;
  end

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (flush) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) wr_d = wr_q + PTR_ONE;
      if (pop)  rd_d = rd_q + PTR_ONE;
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + CNT_ONE;
        2'b01:   cnt_d = cnt_q - CNT_ONE;
        default: cnt_d = cnt_q;
      endcase
    end
  end

endmodule

// File: tb/tb_path_writeback_fsm.sv
// Directed bench for path_writeback_fsm: default instance plus a MAX_LEN=2 instance sharing inputs.
// Expectations include the checksum word when PATH_CHECKSUM_EN is defined.
module tb_path_writeback_fsm;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        node_valid = 1'b0;
  logic [15:0] node_id = '0;
  logic        node_last = 1'b0;
  logic        bus_grant = 1'b0;

  logic        rdy_a, we_a, io_a, ovf_a, fin_o_a;
  logic [15:0] addr_a, wd_a, plen_a;
  logic        rdy_b, we_b, io_b, ovf_b, fin_o_b;
  logic [15:0] addr_b, wd_b, plen_b;

  int n_checks = 0;
  int n_err    = 0;
  int io_bad   = 0;
  int fin_a    = 0;
  int fin_b    = 0;
  logic [31:0] qa[$];
  logic [31:0] qb[$];
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  path_writeback_fsm dut_a (
    .clk(clk), .reset(reset), .start(start), .node_valid(node_valid), .node_ready(rdy_a),
    .node_id(node_id), .node_last(node_last), .bus_grant(bus_grant), .address(addr_a),
    .writedata(wd_a), .write_enable(we_a), .io_enable(io_a), .path_len(plen_a),
    .overflow(ovf_a), .finished(fin_o_a)
  );

  path_writeback_fsm #(.MAX_LEN(2)) dut_b (
    .clk(clk), .reset(reset), .start(start), .node_valid(node_valid), .node_ready(rdy_b),
    .node_id(node_id), .node_last(node_last), .bus_grant(bus_grant), .address(addr_b),
    .writedata(wd_b), .write_enable(we_b), .io_enable(io_b), .path_len(plen_b),
    .overflow(ovf_b), .finished(fin_o_b)
  );

  always @(negedge clk) begin
    if (!reset) begin
      if (we_a) qa.push_back({addr_a, wd_a});
      if (we_b) qb.push_back({addr_b, wd_b});
      if (fin_o_a) fin_a++;
      if (fin_o_b) fin_b++;
      if (io_a != !we_a || io_b != !we_b) io_bad++;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic push_node(input logic [15:0] id, input logic last);
    int n;
    @(negedge clk);
    node_valid = 1'b1;
    node_id    = id;
    node_last  = last;
    #1;
    n = 0;
    while (!(rdy_a && rdy_b) && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 200) check_val("push_timeout", 32'(n), 32'(0));
    @(posedge clk);
    #1;
    node_valid = 1'b0;
    node_last  = 1'b0;
  endtask

  task automatic wait_fin(input int f0);
    int n;
    n = 0;
    while (fin_a == f0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) check_val("finish_timeout", 32'(n), 32'(0));
    repeat (3) @(negedge clk);
  endtask

  task automatic compare_writes(input string tag, input bit use_b, input int sa);
    int got_n;
    logic [31:0] obs;
    got_n = use_b ? qb.size() - sa : qa.size() - sa;
    check_val({tag, "_nwrites"}, 32'(got_n), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      obs = 32'hDEADBEEF;
      if (i < got_n) obs = use_b ? qb[sa + i] : qa[sa + i];
      check_val($sformatf("%s_w%0d", tag, i), obs, exp_q[i]);
    end
  endtask

  task automatic run_basic(input string tag);
    int sa, f0;
    sa = qa.size();
    f0 = fin_a;
    bus_grant = 1'b1;
    pulse_start();
    push_node(16'h0003, 1'b0);
    @(negedge clk);
    check_val({tag, "_lat1_we"}, 32'(we_a), 32'(0));
    @(negedge clk);
    check_val({tag, "_lat2_bus"}, {we_a, io_a, 14'd0, addr_a}, {1'b1, 1'b0, 14'd0, 16'h0902});
    push_node(16'h0007, 1'b0);
    push_node(16'h0001, 1'b1);
    wait_fin(f0);
    exp_q.delete();
    exp_q.push_back(32'h0902_0003);
    exp_q.push_back(32'h0904_0007);
    exp_q.push_back(32'h0906_0001);
    exp_q.push_back(32'h0908_FFFF);
    exp_q.push_back(32'h0900_0003);
`ifdef PATH_CHECKSUM_EN
    exp_q.push_back(32'h090A_0005);
`endif
    compare_writes(tag, 1'b0, sa);
    check_val({tag, "_path_len"}, 32'(plen_a), 32'd3);
    check_val({tag, "_fin_pulses"}, 32'(fin_a - f0), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sa, sb, f0;

    repeat (3) @(negedge clk);
    check_val("rst_bus", {we_a, io_a, fin_o_a, ovf_a, rdy_a, 11'd0, addr_a},
              {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'd0, 16'h0000});
    check_val("rst_data", {wd_a, plen_a}, 32'h0000_0000);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_val("idle_ready", 32'(rdy_a), 32'(0));

    run_basic("basic");

    // Bus stall: four pushes fill the FIFO, nothing reaches the bus until grant returns.
    sa = qa.size();
    f0 = fin_a;
    bus_grant = 1'b0;
    pulse_start();
    push_node(16'h0003, 1'b0);
    push_node(16'h0007, 1'b0);
    push_node(16'h0002, 1'b0);
    push_node(16'h0004, 1'b0);
    repeat (10) @(negedge clk);
    #1;
    check_val("stall_ready_full", 32'(rdy_a), 32'(0));
    check_val("stall_no_writes", 32'(qa.size() - sa), 32'(0));
    @(negedge clk);
    bus_grant = 1'b1;
    #1;
    check_val("stall_ready_on_pop", 32'(rdy_a), 32'(1));
    push_node(16'h0001, 1'b1);
    wait_fin(f0);
    exp_q.delete();
    exp_q.push_back(32'h0902_0003);
    exp_q.push_back(32'h0904_0007);
    exp_q.push_back(32'h0906_0002);
    exp_q.push_back(32'h0908_0004);
    exp_q.push_back(32'h090A_0001);
    exp_q.push_back(32'h090C_FFFF);
    exp_q.push_back(32'h0900_0005);
`ifdef PATH_CHECKSUM_EN
    exp_q.push_back(32'h090E_0003);
`endif
    compare_writes("stall", 1'b0, sa);
    check_val("stall_path_len", 32'(plen_a), 32'd5);

    // Overflow on the MAX_LEN=2 instance.
    sa = qa.size();
    sb = qb.size();
    f0 = fin_b;
    pulse_start();
    push_node(16'h0011, 1'b0);
    push_node(16'h0022, 1'b0);
    push_node(16'h0033, 1'b0);
    push_node(16'h0044, 1'b0);
    push_node(16'h0055, 1'b1);
    wait_fin(fin_a);
    exp_q.delete();
    exp_q.push_back(32'h0902_0011);
    exp_q.push_back(32'h0904_0022);
    exp_q.push_back(32'h0906_FFFF);
    exp_q.push_back(32'h0900_0002);
`ifdef PATH_CHECKSUM_EN
    exp_q.push_back(32'h0908_0033);
`endif
    compare_writes("ovf", 1'b1, sb);
    check_val("ovf_flag_b", 32'(ovf_b), 32'(1));
    check_val("ovf_path_len_b", 32'(plen_b), 32'd2);
    check_val("ovf_fin_b", 32'(fin_b - f0), 32'd1);
    check_val("ovf_flag_a", 32'(ovf_a), 32'(0));
    check_val("ovf_path_len_a", 32'(plen_a), 32'd5);

    // Sentinel-only path; start also clears the sticky overflow.
    sa = qa.size();
    f0 = fin_a;
    pulse_start();
    check_val("start_clears_ovf", 32'(ovf_b), 32'(0));
    push_node(16'hFFFF, 1'b0);
    wait_fin(f0);
    exp_q.delete();
    exp_q.push_back(32'h0902_FFFF);
    exp_q.push_back(32'h0900_0000);
`ifdef PATH_CHECKSUM_EN
    exp_q.push_back(32'h0904_0000);
`endif
    compare_writes("sentinel", 1'b0, sa);
    check_val("sentinel_path_len", 32'(plen_a), 32'd0);
    check_val("sentinel_fin", 32'(fin_a - f0), 32'd1);

    // Asynchronous reset while a node write is on the bus.
    pulse_start();
    push_node(16'h0009, 1'b0);
    @(posedge clk);
    #1;
    check_val("arst_pre_we", 32'(we_a), 32'(1));
    #1;
    reset = 1'b1;
    #1;
    check_val("arst_bus", {29'd0, we_a, io_a, fin_o_a}, {29'd0, 1'b0, 1'b1, 1'b0});
    check_val("arst_idle_ready", 32'(rdy_a), 32'(0));
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    run_basic("after_rst");

    check_val("io_vs_we", 32'(io_bad), 32'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
